// File: rtl/xor_mismatch_monitor_if.sv
// Bundle of the comparator-side sample stream and the monitor's status outputs.
// The master drives samples and clear; the slave (the monitor) returns its status.
interface xor_mismatch_monitor_if #(
  parameter int CNT_W = 8
);

  logic             clear;
  logic             in_valid;
  logic             in_bit;
  logic             alarm;
  logic             alarm_rise;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] ones_total;
  logic             parity;

  modport master (
    output clear,
    output in_valid,
    output in_bit,
    input  alarm,
    input  alarm_rise,
    input  run_len,
    input  ones_total,
    input  parity
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  in_bit,
    output alarm,
    output alarm_rise,
    output run_len,
    output ones_total,
    output parity
  );

endinterface

// File: rtl/xor_mismatch_monitor.sv
// Watches the registered XOR mismatch bit: raises a sticky alarm after a run of
// mismatches, releases it after a run of matches, and keeps totals and parity.
module xor_mismatch_monitor #(
  parameter int RUN_THRESH = 4,
  parameter int CLR_LEN    = 3,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  areset_n,
  xor_mismatch_monitor_if.slave mon
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_ALARM = 2'd2;
  localparam logic [1:0] S_COOL  = 2'd3;

  localparam int               ZW       = $clog2(CLR_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(RUN_THRESH);
  localparam logic [ZW-1:0]    ZLIM     = ZW'(CLR_LEN);

  logic [1:0]       state_q,      state_nxt;
  logic [ZW-1:0]    zcnt_q,       zcnt_nxt;
  logic [CNT_W-1:0] run_len_q,    run_len_nxt;
  logic [CNT_W-1:0] ones_total_q, ones_total_nxt;
  logic             parity_q,     parity_nxt;
  logic             alarm_q,      alarm_nxt;
  logic             alarm_rise_q;
  logic [ZW-1:0]    zcnt_inc;

  assign zcnt_inc = zcnt_q + ZW'(1);

  // Datapath counters: both counters saturate instead of wrapping, so a very
  // long run keeps meeting the threshold and the alarm cannot drop by overflow.
  always_comb begin
    run_len_nxt    = run_len_q;
    ones_total_nxt = ones_total_q;
    parity_nxt     = parity_q;
    if (mon.in_valid) begin
      if (mon.in_bit) begin
        if (run_len_q != CNT_MAX) begin
          run_len_nxt = run_len_q + CNT_W'(1);
        end
        if (ones_total_q != CNT_MAX) begin
          ones_total_nxt = ones_total_q + CNT_W'(1);
        end
        parity_nxt = ~parity_q;
      end else begin
        run_len_nxt = '0;
      end
    end
  end

  // Alarm FSM; the threshold test uses the post-increment run length so the
  // alarm appears right after the edge that samples the qualifying 1.
  always_comb begin
    state_nxt = state_q;
    zcnt_nxt  = zcnt_q;
    if (mon.in_valid) begin
      case (state_q)
        S_IDLE: begin
          if (mon.in_bit) begin
            state_nxt = (run_len_nxt >= THRESH) ? S_ALARM : S_RUN;
          end
        end
        S_RUN: begin
          if (!mon.in_bit) begin
            state_nxt = S_IDLE;
          end else if (run_len_nxt >= THRESH) begin
            state_nxt = S_ALARM;
          end
        end
        S_ALARM: begin
          if (!mon.in_bit) begin
            if (CLR_LEN == 1) begin
              state_nxt = S_IDLE;
              zcnt_nxt  = '0;
            end else begin
              state_nxt = S_COOL;
              zcnt_nxt  = ZW'(1);
            end
          end
        end
        default: begin
          if (mon.in_bit) begin
            state_nxt = S_ALARM;
            zcnt_nxt  = '0;
          end else if (zcnt_inc >= ZLIM) begin
            state_nxt = S_IDLE;
            zcnt_nxt  = '0;
          end else begin
            zcnt_nxt  = zcnt_inc;
          end
        end
      endcase
    end
  end

  assign alarm_nxt = (state_nxt == S_ALARM) || (state_nxt == S_COOL);

  // State registers; clear behaves like reset and discards a coincident sample.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= S_IDLE;
      zcnt_q       <= '0;
      run_len_q    <= '0;
      ones_total_q <= '0;
      parity_q     <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_rise_q <= 1'b0;
    end else if (mon.clear) begin
      state_q      <= S_IDLE;
      zcnt_q       <= '0;
      run_len_q    <= '0;
      ones_total_q <= '0;
      parity_q     <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_rise_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      zcnt_q       <= zcnt_nxt;
      run_len_q    <= run_len_nxt;
      ones_total_q <= ones_total_nxt;
      parity_q     <= parity_nxt;
      alarm_q      <= alarm_nxt;
      alarm_rise_q <= alarm_nxt & ~alarm_q;
    end
  end

  assign mon.alarm      = alarm_q;
  assign mon.alarm_rise = alarm_rise_q;
  assign mon.run_len    = run_len_q;
  assign mon.ones_total = ones_total_q;
  assign mon.parity     = parity_q;

endmodule

// File: tb/tb_xor_mismatch_monitor.sv
// Self-checking bench for xor_mismatch_monitor: directed scenarios plus random
// traffic, compared every cycle against a run/total/parity model of the rules.
module tb_xor_mismatch_monitor;

  localparam int RUN_THRESH = 4;
  localparam int CLR_LEN    = 3;
  localparam int CNT_W      = 8;
  localparam int MAXV       = (1 << CNT_W) - 1;

  logic clk      = 1'b0;
  logic areset_n = 1'b0;

  always #5 clk = ~clk;

  xor_mismatch_monitor_if #(.CNT_W(CNT_W)) bus ();

  xor_mismatch_monitor #(
    .RUN_THRESH(RUN_THRESH),
    .CLR_LEN   (CLR_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk     (clk),
    .areset_n(areset_n),
    .mon     (bus)
  );

  int passCount  = 0;
  int checkCount = 0;
  int riseCount  = 0;

  int mRun   = 0;
  int mTotal = 0;
  int mZeros = 0;
  bit mPar   = 1'b0;
  bit mAlarm = 1'b0;
  bit mRise  = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic modelZero();
    mRun   = 0;
    mTotal = 0;
    mZeros = 0;
    mPar   = 1'b0;
    mAlarm = 1'b0;
    mRise  = 1'b0;
  endtask

  // Model in terms of the rules: alarm turns on when the 1-run reaches the
  // threshold, turns off after CLR_LEN consecutive 0s while alarmed.
  task automatic modelStep(input bit clr, input bit v, input bit b);
    mRise = 1'b0;
    if (clr) begin
      modelZero();
    end else if (v) begin
      if (b) begin
        mRun   = (mRun   < MAXV) ? mRun + 1   : MAXV;
        mTotal = (mTotal < MAXV) ? mTotal + 1 : MAXV;
        mPar   = ~mPar;
        if (mAlarm) begin
          mZeros = 0;
        end else if (mRun >= RUN_THRESH) begin
          mAlarm = 1'b1;
          mRise  = 1'b1;
        end
      end else begin
        mRun = 0;
        if (mAlarm) begin
          mZeros++;
          if (mZeros >= CLR_LEN) begin
            mAlarm = 1'b0;
            mZeros = 0;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit clr, input bit v, input bit b);
    @(negedge clk);
    bus.clear    = clr;
    bus.in_valid = v;
    bus.in_bit   = b;
    modelStep(clr, v, b);
    @(posedge clk);
    #2;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic midCycleReset();
    #1;
    areset_n = 1'b0;
    modelZero();
    #1;
    checkOutput("async_reset_alarm",      int'(bus.alarm),      0);
    checkOutput("async_reset_rise",       int'(bus.alarm_rise), 0);
    checkOutput("async_reset_run_len",    int'(bus.run_len),    0);
    checkOutput("async_reset_ones_total", int'(bus.ones_total), 0);
    checkOutput("async_reset_parity",     int'(bus.parity),     0);
    @(negedge clk);
    areset_n = 1'b1;
  endtask

  // Per-cycle compare against the model, just after each active edge.
  always @(posedge clk) begin
    #1;
    checkOutput("alarm",      int'(bus.alarm),      int'(mAlarm));
    checkOutput("alarm_rise", int'(bus.alarm_rise), int'(mRise));
    checkOutput("run_len",    int'(bus.run_len),    mRun);
    checkOutput("ones_total", int'(bus.ones_total), mTotal);
    checkOutput("parity",     int'(bus.parity),     int'(mPar));
    if (bus.alarm_rise) riseCount++;
  end

  initial begin
    int r0;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    modelZero();
    repeat (2) @(negedge clk);
    areset_n = 1'b1;

    // Reset mid-run, then a fresh run of four raises the alarm.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    midCycleReset();
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s1_no_alarm_after_3", int'(bus.alarm), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s1_alarm_after_4", int'(bus.alarm), 1);

    // Alarm raise from a clean start.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("s2_run_len", int'(bus.run_len), i);
    end
    checkOutput("s2_alarm",      int'(bus.alarm),      1);
    checkOutput("s2_rise",       int'(bus.alarm_rise), 1);
    checkOutput("s2_ones_total", int'(bus.ones_total), 4);
    checkOutput("s2_parity",     int'(bus.parity),     0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s2_rise_drop",  int'(bus.alarm_rise), 0);

    // Broken run with idle gaps.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("s3_run_len_3", int'(bus.run_len), 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s3_run_len_0", int'(bus.run_len), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s3_run_len_1",  int'(bus.run_len),    1);
    checkOutput("s3_alarm",      int'(bus.alarm),      0);
    checkOutput("s3_ones_total", int'(bus.ones_total), 4);
    checkOutput("s3_parity",     int'(bus.parity),     0);

    // Cooldown with a re-entry, then release.
    applyStimulus(1'b1, 1'b0, 1'b0);
    r0 = riseCount;
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s4_alarm_cool", int'(bus.alarm), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s4_alarm_reentry", int'(bus.alarm),      1);
    checkOutput("s4_no_second_rise", int'(bus.alarm_rise), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s4_alarm_before_3rd", int'(bus.alarm), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s4_alarm_released", int'(bus.alarm), 0);
    checkOutput("s4_rise_count", riseCount - r0, 1);

    // Saturation over 300 consecutive ones.
    applyStimulus(1'b1, 1'b0, 1'b0);
    r0 = riseCount;
    repeat (300) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s5_run_len",    int'(bus.run_len),    255);
    checkOutput("s5_ones_total", int'(bus.ones_total), 255);
    checkOutput("s5_parity",     int'(bus.parity),     0);
    checkOutput("s5_alarm",      int'(bus.alarm),      1);
    checkOutput("s5_rise_count", riseCount - r0,       1);

    // Clear beats a coincident valid 1 while alarmed.
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("s6_alarm",      int'(bus.alarm),      0);
    checkOutput("s6_rise",       int'(bus.alarm_rise), 0);
    checkOutput("s6_run_len",    int'(bus.run_len),    0);
    checkOutput("s6_ones_total", int'(bus.ones_total), 0);
    checkOutput("s6_parity",     int'(bus.parity),     0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s6_run_len_1",    int'(bus.run_len),    1);
    checkOutput("s6_ones_total_1", int'(bus.ones_total), 1);
    checkOutput("s6_parity_1",     int'(bus.parity),     1);

    // Random traffic with bursty bits, rare clears and rare async resets.
    for (int i = 0; i < 4000; i++) begin
      bit clr;
      bit v;
      bit b;
      clr = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 9) < 7);
      b   = ($urandom_range(0, 9) < ((i / 200) % 2 == 0 ? 7 : 4));
      applyStimulus(clr, v, b);
      if ($urandom_range(0, 499) == 0) midCycleReset();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/xor_mismatch_monitor.md
# xor_mismatch_monitor

- Sits directly downstream of the two-input XOR comparator stage and consumes its registered mismatch bit (`a ^ b`).
- Counts consecutive mismatches, raises a sticky alarm after a configurable run length, and releases it after a configurable run of matches.
- Also keeps a saturating total of mismatches and a running parity of all sampled bits.
- Intended as the first sequential consumer of the comparator output in the example designs.

## Interface

Parameters:

- `RUN_THRESH`, default 4: consecutive valid 1s needed to raise the alarm. Legal range is 1 to 2^CNT_W-1.
- `CLR_LEN`, default 3: consecutive valid 0s needed to release the alarm. Must be at least 1.
- `CNT_W`, default 8: width of the `run_len` and `ones_total` counters.

Ports:

- `clk`  in  1: single clock, rising edge.
- `areset_n`  in  1: one clock; reset is asynchronous and active-low.
- `clear`  in  1: synchronous clear. Highest priority after reset.
- `in_valid`  in  1: `in_bit` is sampled on this edge.
- `in_bit`  in  1: mismatch bit from the XOR comparator.
- `alarm`  out  1: mismatch alarm, level output.
- `alarm_rise`  out  1: one-cycle pulse when `alarm` goes 0->1.
- `run_len`  out  CNT_W: current count of consecutive valid 1s, saturating.
- `ones_total`  out  CNT_W: total valid 1s since reset or clear, saturating.
- `parity`  out  1: XOR of all valid bits since reset or clear.

## Operation

- **Reset:** while `areset_n` is 0, all outputs and internal state are 0 and the FSM is in IDLE.
- **Clear:** `clear`=1 at an edge forces the same reset state. It overrides a simultaneous `in_valid`; that sample is discarded.
- **No valid input:** `in_valid`=0 holds all state. `alarm_rise` is 0.
- **Sampling a valid bit:**
  - Bit 1: `run_len` increments, saturating at 2^CNT_W-1. `ones_total` increments, saturating. `parity` toggles.
  - Bit 0: `run_len` goes to 0. `parity` is unchanged.
- **FSM** (`zcnt` is an internal zero counter, 0..CLR_LEN):
  - IDLE:
    - valid 1 -> RUN, or -> ALARM directly if RUN_THRESH=1.
    - valid 0 -> stays in IDLE.
  - RUN:
    - valid 1 where the new `run_len` >= RUN_THRESH -> ALARM.
    - valid 1 otherwise -> stays in RUN.
    - valid 0 -> IDLE.
  - ALARM:
    - valid 1 -> stays in ALARM.
    - valid 0 -> COOL with `zcnt`=1, or -> IDLE directly if CLR_LEN=1.
  - COOL:
    - valid 0 -> `zcnt`+1; when `zcnt` reaches CLR_LEN -> IDLE.
    - valid 1 -> ALARM, with `zcnt` cleared.
- **Outputs derived from the FSM:**
  - `alarm` = (state is ALARM or COOL), driven from a register.
  - `alarm_rise` = 1 for exactly the one cycle in which `alarm` first becomes 1 after being 0.
  - A COOL->ALARM re-entry does not pulse `alarm_rise`, because `alarm` stayed 1.
- **Saturation:** a saturated `run_len` still satisfies the threshold, so the alarm persists. Counters never wrap.

## Timing

- All outputs are registered. A sample taken at edge k is reflected in the outputs immediately after edge k, so latency is 1 cycle.
- The alarm is asserted after the edge that samples the RUN_THRESH-th consecutive valid 1. Gaps with `in_valid`=0 do not break a run.
- The alarm is deasserted after the edge that samples the CLR_LEN-th consecutive valid 0.
- Asynchronous reset takes effect without waiting for a clock edge. Deassertion is assumed synchronised upstream.
- If reset is asserted mid-run, the next run starts from 0.
- Priority when events coincide at the same edge: `areset_n` > `clear` > valid sample.

## Test plan

Defaults for all scenarios: RUN_THRESH=4, CLR_LEN=3, CNT_W=8.

1. **Reset mid-run.** Feed valid 1,1,1, then pull `areset_n` low between edges.
   - Required: all outputs are 0 immediately.
   - After release, valid 1 x4 -> `alarm`=1 after the 4th edge.
2. **Alarm raise.** Feed valid 1,1,1,1.
   - Required: `run_len` = 1,2,3,4.
   - `alarm` and `alarm_rise` go to 1 after the 4th edge.
   - `alarm_rise` returns to 0 on the next edge.
   - `ones_total`=4, `parity`=0.
3. **Broken run with gaps.** Feed valid 1,1,1,0,1, with `in_valid`=0 cycles interleaved.
   - Required: `alarm` stays 0 throughout.
   - `run_len` goes 3 -> 0 -> 1.
   - `ones_total`=4, `parity`=0.
4. **Cooldown and re-entry.** Raise the alarm, then feed 0,0,1,0,0,0.
   - Required: `alarm` stays 1 through the 1 (re-entry to ALARM, no second `alarm_rise`).
   - `alarm` drops to 0 after the third consecutive 0.
5. **Saturation.** Feed 300 consecutive valid 1s.
   - Required: `run_len`=255 and `ones_total`=255, with no wrap.
   - `parity`=0.
   - `alarm`=1, and exactly one `alarm_rise` pulse over the whole sequence.
6. **Clear priority.** With the alarm active, assert `clear` together with valid 1.
   - Required: next cycle all outputs are 0; the sample is discarded.
   - A following valid 1 -> `run_len`=1, `ones_total`=1, `parity`=1.
